// File: rtl/data_bus_adapter.sv
// rtl/data_bus_adapter.sv - core data port to word-aligned valid/ready bus adapter
// Stalls the core across bus wait states and faults on misalignment or timeout.
module data_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] core_address,
  input  logic [1:0]  core_width,
  input  logic [31:0] core_wdata,
  input  logic        core_read,
  input  logic        core_write,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_en,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, REQ, RSP, DONE, FAULT} state_t;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] count;
  logic [1:0]  offset;
  logic [1:0]  width;
  logic        request;
  logic        bad;
  logic [3:0]  byte_en_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] rdata_next;

  assign request    = core_read | core_write;
  assign core_stall = ((state == IDLE) && request) || (state == REQ) || (state == RSP);

  always_comb begin
    bad = (core_read & core_write)
        | (core_width == 2'd3)
        | ((core_width == 2'd1) & core_address[0])
        | ((core_width == 2'd2) & (core_address[1:0] != 2'b00));
  end

  always_comb begin
    byte_en_next = 4'b1111;
    wdata_next   = core_wdata;
    case (core_width)
      2'd0: begin
        byte_en_next = 4'b0001 << core_address[1:0];
        wdata_next   = {4{core_wdata[7:0]}};
      end
      2'd1: begin
        byte_en_next = core_address[1] ? 4'b1100 : 4'b0011;
        wdata_next   = {2{core_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Read data comes back on the lanes selected by the original byte offset.
  always_comb begin
    shifted = bus_rdata >> {offset, 3'b000};
    case (width)
      2'd0:    rdata_next = {24'd0, shifted[7:0]};
      2'd1:    rdata_next = {16'd0, shifted[15:0]};
      default: rdata_next = shifted;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      offset      <= '0;
      width       <= '0;
      bus_valid   <= 1'b0;
      bus_write   <= 1'b0;
      bus_byte_en <= '0;
      bus_address <= '0;
      bus_wdata   <= '0;
      core_rdata  <= '0;
      core_fault  <= 1'b0;
    end else begin
      core_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            if (bad) begin
              state      <= FAULT;
              core_fault <= 1'b1;
              core_rdata <= '0;
            end else begin
              state       <= REQ;
              bus_valid   <= 1'b1;
              bus_address <= {core_address[31:2], 2'b00};
              bus_byte_en <= byte_en_next;
              bus_write   <= core_write;
              bus_wdata   <= wdata_next;
              offset      <= core_address[1:0];
              width       <= core_width;
              count       <= '0;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= bus_write ? DONE : RSP;
            count     <= count + 16'd1;
          end else if (count == LAST_COUNT) begin
            bus_valid  <= 1'b0;
            state      <= FAULT;
            core_fault <= 1'b1;
            core_rdata <= '0;
          end else begin
            count <= count + 16'd1;
          end
        end
        RSP: begin
          if (bus_rsp_valid) begin
            core_rdata <= rdata_next;
            state      <= DONE;
          end else if (count == LAST_COUNT) begin
            state      <= FAULT;
            core_fault <= 1'b1;
            core_rdata <= '0;
          end else begin
            count <= count + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
